// File: rtl/serial_tx_if.sv
// Host-side handshake and serial line of the UART transmitter.
// The host drives DATA/WR; the transmitter returns WR_ACK, TX and BUSY.
interface serial_tx_if;
    logic [7:0] DATA;
    logic       WR;
    logic       WR_ACK;
    logic       TX;
    logic       BUSY;

    modport master (output DATA, output WR, input WR_ACK, input TX, input BUSY);
    modport slave  (input DATA, input WR, output WR_ACK, output TX, output BUSY);
endinterface

// File: rtl/serial_tx.sv
// UART transmitter on the 16x oversampling clock: synchronized request/acknowledge
// intake into a one-byte holding register, then start/data/parity/stop framing LSB first.
module serial_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       CLK_RX,
    input  logic       RST,
    serial_tx_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] TICK_RELOAD = 4'(OVERSAMPLE - 1);
    localparam logic       LAST_STOP   = 1'(STOP_BITS - 1);
    localparam logic       PARITY_EN   = (PARITY != 0);
    localparam logic       PARITY_ODD  = (PARITY == 2);

    function automatic logic parity_bit(input logic [7:0] byte_v, input logic odd_v);
        return (^byte_v) ^ odd_v;
    endfunction

    state_t     state_r;
    logic       wr_s1_r;
    logic       wr_s2_r;
    logic [7:0] hold_r;
    logic       hold_full_r;
    logic [7:0] shift_r;
    logic       par_r;
    logic [3:0] tick_r;
    logic [2:0] bit_cnt_r;
    logic       stop_cnt_r;
    logic       tx_r;
    logic       wr_ack_r;
    logic       busy_r;

    logic tick_done_s;
    logic stop_last_s;
    logic accept_s;
    logic load_s;
    logic hold_full_nxt_s;
    logic idle_nxt_s;

    // Intake and shifter-load decisions; BUSY is built from the same next values
    always_comb begin
        tick_done_s     = (tick_r == 4'd0);
        stop_last_s     = (state_r == ST_STOP) && tick_done_s && (stop_cnt_r == LAST_STOP);
        accept_s        = wr_s2_r && !wr_ack_r && !hold_full_r;
        load_s          = hold_full_r && ((state_r == ST_IDLE) || stop_last_s);
        hold_full_nxt_s = accept_s || (hold_full_r && !load_s);
        idle_nxt_s      = !hold_full_r && ((state_r == ST_IDLE) || stop_last_s);
    end

    // Synchronizer, handshake, holding register and framing FSM
    always_ff @(posedge CLK_RX) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            wr_s1_r     <= 1'b0;
            wr_s2_r     <= 1'b0;
            hold_r      <= 8'd0;
            hold_full_r <= 1'b0;
            shift_r     <= 8'd0;
            par_r       <= 1'b0;
            tick_r      <= 4'd0;
            bit_cnt_r   <= 3'd0;
            stop_cnt_r  <= 1'b0;
            tx_r        <= 1'b1;
            wr_ack_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            wr_s1_r     <= bus.WR;
            wr_s2_r     <= wr_s1_r;
            hold_full_r <= hold_full_nxt_s;
            busy_r      <= hold_full_nxt_s || !idle_nxt_s;

            // ACK rises on accept and drops only once the synchronized request is low
            if (accept_s) begin
                wr_ack_r <= 1'b1;
                hold_r   <= bus.DATA;
            end else if (!wr_s2_r) begin
                wr_ack_r <= 1'b0;
            end else begin
                wr_ack_r <= wr_ack_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r <= ST_START;
                        tick_r  <= TICK_RELOAD;
                        shift_r <= hold_r;
                        par_r   <= parity_bit(hold_r, PARITY_ODD);
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_done_s) begin
                        state_r   <= ST_DATA;
                        tick_r    <= TICK_RELOAD;
                        bit_cnt_r <= 3'd0;
                        tx_r      <= shift_r[0];
                    end else begin
                        tick_r    <= tick_r - 4'd1;
                    end
                end
                ST_DATA: begin
                    if (!tick_done_s) begin
                        tick_r <= tick_r - 4'd1;
                    end else if (bit_cnt_r != 3'd7) begin
                        tick_r    <= TICK_RELOAD;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        shift_r   <= {1'b0, shift_r[7:1]};
                        tx_r      <= shift_r[1];
                    end else if (PARITY_EN) begin
                        state_r <= ST_PARITY;
                        tick_r  <= TICK_RELOAD;
                        tx_r    <= par_r;
                    end else begin
                        state_r    <= ST_STOP;
                        tick_r     <= TICK_RELOAD;
                        stop_cnt_r <= 1'b0;
                        tx_r       <= 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tick_done_s) begin
                        state_r    <= ST_STOP;
                        tick_r     <= TICK_RELOAD;
                        stop_cnt_r <= 1'b0;
                        tx_r       <= 1'b1;
                    end else begin
                        tick_r     <= tick_r - 4'd1;
                    end
                end
                ST_STOP: begin
                    // A byte waiting in the holding register starts immediately, no idle cycle
                    if (!tick_done_s) begin
                        tick_r <= tick_r - 4'd1;
                    end else if (stop_cnt_r != LAST_STOP) begin
                        tick_r     <= TICK_RELOAD;
                        stop_cnt_r <= 1'b1;
                    end else if (load_s) begin
                        state_r <= ST_START;
                        tick_r  <= TICK_RELOAD;
                        shift_r <= hold_r;
                        par_r   <= parity_bit(hold_r, PARITY_ODD);
                        tx_r    <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        tx_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tick_r  <= 4'd0;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.TX     = tx_r;
    assign bus.WR_ACK = wr_ack_r;
    assign bus.BUSY   = busy_r;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three configurations (8N1, 8E2, 8O1) driven by host tasks; a per-DUT
// UART line decoder pops expected bytes from a scoreboard queue and checks every frame cycle.
module tb_serial_tx;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Edge counter: after edge n, cyc == n
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx_if bus0 ();
    serial_tx_if bus1 ();
    serial_tx_if bus2 ();

    serial_tx #(.OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_dut0 (.CLK_RX(clk), .RST(rst), .bus(bus0.slave));
    serial_tx #(.OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2)) u_dut1 (.CLK_RX(clk), .RST(rst), .bus(bus1.slave));
    serial_tx #(.OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_dut2 (.CLK_RX(clk), .RST(rst), .bus(bus2.slave));

    logic [2:0] wr_d = 3'b000;
    logic [7:0] data_d [3];
    logic [2:0] tx_w, ack_w, busy_w;

    assign bus0.WR = wr_d[0];
    assign bus1.WR = wr_d[1];
    assign bus2.WR = wr_d[2];
    assign bus0.DATA = data_d[0];
    assign bus1.DATA = data_d[1];
    assign bus2.DATA = data_d[2];
    assign tx_w   = {bus2.TX, bus1.TX, bus0.TX};
    assign ack_w  = {bus2.WR_ACK, bus1.WR_ACK, bus0.WR_ACK};
    assign busy_w = {bus2.BUSY, bus1.BUSY, bus0.BUSY};

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [3][$];
    int frames_started [3];
    int frames_done    [3];
    int last_start     [3];
    int prev_start     [3];
    bit in_frame       [3];

    function automatic int par_of(input int idx);
        return idx;
    endfunction

    function automatic int stops_of(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic at_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic raise(input int idx, input logic [7:0] d, output int j);
        @(posedge clk); #1;
        data_d[idx] = d;
        wr_d[idx]   = 1'b1;
        exp_q[idx].push_back(d);
        j = cyc;
    endtask

    task automatic lower(input int idx, output int m);
        @(posedge clk); #1;
        wr_d[idx] = 1'b0;
        m = cyc + 1;
    endtask

    task automatic wait_ack(input int idx, input logic lvl, input int budget, input string name);
        int t;
        t = 0;
        while (ack_w[idx] !== lvl && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(name, int'(ack_w[idx]), int'(lvl));
    endtask

    task automatic send(input int idx, input logic [7:0] d, input int hold);
        int j, m;
        raise(idx, d, j);
        wait_ack(idx, 1'b1, 1000, $sformatf("send%0d_ack_rise", idx));
        repeat (hold) @(posedge clk);
        lower(idx, m);
        wait_ack(idx, 1'b0, 10, $sformatf("send%0d_ack_fall", idx));
    endtask

    task automatic wait_idle(input int idx);
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q[idx].size() != 0 || busy_w[idx] !== 1'b0 || in_frame[idx]) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("idle%0d_reached", idx), int'(t < 3000), 1);
    endtask

    // Line decoder: expected frame is start 0, data LSB first, optional parity, stop 1s
    task automatic mon(input int idx);
        logic [15:0] bits;
        logic [7:0]  d;
        int          nb, bad;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst && tx_w[idx] === 1'b0) begin
                frames_started[idx]++;
                prev_start[idx] = last_start[idx];
                last_start[idx] = cyc;
                in_frame[idx]   = 1'b1;
                if (exp_q[idx].size() == 0) begin
                    chk($sformatf("unexpected_frame%0d", idx), 1, 0);
                    d = 8'h00;
                end else begin
                    d = exp_q[idx].pop_front();
                end
                bits = 16'hFFFF;
                bits[0] = 1'b0;
                for (int b = 0; b < 8; b++) bits[1 + b] = d[b];
                nb = 9;
                if (par_of(idx) != 0) begin
                    bits[nb] = (^d) ^ (par_of(idx) == 2);
                    nb++;
                end
                nb += stops_of(idx);
                bad = 0;
                aborted = 1'b0;
                for (int c = 0; c < nb * OS; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx_w[idx] !== bits[c / OS]) bad++;
                end
                if (!aborted) begin
                    chk($sformatf("frame%0d_byte%02h_bad_cycles", idx, d), bad, 0);
                    frames_done[idx]++;
                end
                in_frame[idx] = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, required completion before %0d cycles", 60000);
        $fatal(1, "bench timeout");
    end

    initial begin
        int j, m, s, fs, bad, ack_cyc, jc;
        for (int i = 0; i < 3; i++) begin
            data_d[i] = 8'h00;
            frames_started[i] = 0;
            frames_done[i] = 0;
            last_start[i] = 0;
            prev_start[i] = 0;
            in_frame[i] = 1'b0;
        end
        fork
            mon(0);
            mon(1);
            mon(2);
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d_tx", i), int'(tx_w[i]), 1);
            chk($sformatf("reset%0d_ack", i), int'(ack_w[i]), 0);
            chk($sformatf("reset%0d_busy", i), int'(busy_w[i]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // 8N1 0x55: handshake latency, start edge, ack release, BUSY span
        raise(0, 8'h55, j);
        at_edge(j + 2); chk("t1_ack_before_accept", int'(ack_w[0]), 0);
        at_edge(j + 3); chk("t1_ack_at_accept", int'(ack_w[0]), 1);
        chk("t1_busy_at_accept", int'(busy_w[0]), 1);
        chk("t1_tx_idle_at_accept", int'(tx_w[0]), 1);
        at_edge(j + 4); chk("t1_tx_start", int'(tx_w[0]), 0);
        lower(0, m);
        at_edge(m + 1); chk("t1_ack_held", int'(ack_w[0]), 1);
        at_edge(m + 2); chk("t1_ack_released", int'(ack_w[0]), 0);
        at_edge(j + 4 + 16); chk("t1_bit0", int'(tx_w[0]), 1);
        at_edge(j + 4 + 32); chk("t1_bit1", int'(tx_w[0]), 0);
        at_edge(j + 4 + 159); chk("t1_busy_last_stop", int'(busy_w[0]), 1);
        at_edge(j + 4 + 160); chk("t1_busy_fall", int'(busy_w[0]), 0);
        wait_idle(0);

        // Back-to-back 0xA5, 0x3C: second byte acked during frame 1, no gap
        raise(0, 8'hA5, j);
        s = j + 4;
        wait_ack(0, 1'b1, 10, "t2_ack1");
        lower(0, m);
        wait_ack(0, 1'b0, 10, "t2_ack1_fall");
        repeat (40) @(posedge clk);
        raise(0, 8'h3C, jc);
        wait_ack(0, 1'b1, 10, "t2_ack2");
        chk("t2_ack2_in_frame1", int'(cyc < s + 160), 1);
        lower(0, m);
        wait_idle(0);
        chk("t2_frame2_start", last_start[0], s + 160);
        chk("t2_frame1_start", prev_start[0], s);

        // 8E2 with 0x07: parity 1, 32-cycle stop, 192-cycle period back-to-back
        raise(1, 8'h07, j);
        s = j + 4;
        wait_ack(1, 1'b1, 10, "t3_ack_e");
        lower(1, m);
        wait_ack(1, 1'b0, 10, "t3_ackfall_e");
        raise(1, 8'hC3, jc);
        wait_ack(1, 1'b1, 10, "t3_ack_e2");
        lower(1, m);
        at_edge(s + 150); chk("t3_even_parity_bit", int'(tx_w[1]), 1);
        at_edge(s + 191); chk("t3_stop2_end", int'(tx_w[1]), 1);
        at_edge(s + 192); chk("t3_next_start", int'(tx_w[1]), 0);
        wait_idle(1);
        chk("t3_period_192", last_start[1] - prev_start[1], 192);

        // 8O1 with 0x07: parity 0, 176-cycle frame
        raise(2, 8'h07, j);
        s = j + 4;
        wait_ack(2, 1'b1, 10, "t3_ack_o");
        lower(2, m);
        at_edge(s + 150); chk("t3_odd_parity_bit", int'(tx_w[2]), 0);
        at_edge(s + 175); chk("t3_odd_busy_last", int'(busy_w[2]), 1);
        at_edge(s + 176); chk("t3_odd_busy_fall", int'(busy_w[2]), 0);
        wait_idle(2);

        // WR held 1000 cycles: one frame, ack held until 2 edges after WR falls
        fs = frames_started[0];
        raise(0, 8'h81, j);
        bad = 0;
        for (int e = j + 3; e <= j + 1000; e++) begin
            at_edge(e);
            if (ack_w[0] !== 1'b1) bad++;
        end
        chk("t4_ack_held_bad_cycles", bad, 0);
        lower(0, m);
        at_edge(m + 1); chk("t4_ack_before_release", int'(ack_w[0]), 1);
        at_edge(m + 2); chk("t4_ack_release", int'(ack_w[0]), 0);
        wait_idle(0);
        chk("t4_one_frame", frames_started[0] - fs, 1);

        // Hold full: third ack withheld until second byte loads
        fs = frames_done[0];
        raise(0, 8'h11, j);
        s = j + 4;
        wait_ack(0, 1'b1, 10, "t5_ack_a");
        lower(0, m);
        wait_ack(0, 1'b0, 10, "t5_ackfall_a");
        send(0, 8'h22, 0);
        raise(0, 8'h33, jc);
        ack_cyc = -1;
        for (int t = 0; t < 400 && ack_cyc < 0; t++) begin
            @(negedge clk);
            if (ack_w[0] === 1'b1) ack_cyc = cyc;
        end
        chk("t5_third_ack_edge", ack_cyc, s + 161);
        lower(0, m);
        wait_idle(0);
        chk("t5_frames", frames_done[0] - fs, 3);
        chk("t5_third_start", last_start[0], s + 320);

        // Reset mid-DATA of 0x00 aborts the frame
        raise(0, 8'h00, j);
        s = j + 4;
        at_edge(j + 3);
        lower(0, m);
        at_edge(s + 64);
        chk("t6_tx_in_data", int'(tx_w[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_tx_reset", int'(tx_w[0]), 1);
        chk("t6_busy_reset", int'(busy_w[0]), 0);
        chk("t6_ack_reset", int'(ack_w[0]), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        fs = frames_started[0];
        bad = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
        end
        chk("t6_idle_after_reset", bad, 0);
        chk("t6_no_residual_frame", frames_started[0] - fs, 0);

        // Randomized traffic on all three configurations concurrently
        fork
            for (int r = 0; r < 6; r++) begin
                repeat ($urandom_range(0, 250)) @(posedge clk);
                send(0, 8'($urandom()), $urandom_range(0, 5));
            end
            for (int r = 0; r < 6; r++) begin
                repeat ($urandom_range(0, 250)) @(posedge clk);
                send(1, 8'($urandom()), $urandom_range(0, 5));
            end
            for (int r = 0; r < 6; r++) begin
                repeat ($urandom_range(0, 250)) @(posedge clk);
                send(2, 8'($urandom()), $urandom_range(0, 5));
            end
        join
        for (int i = 0; i < 3; i++) begin
            wait_idle(i);
            chk($sformatf("final%0d_queue_empty", i), exp_q[i].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

UART transmitter for the serial link: accepts a byte from the host clock domain through a synchronized four-phase request/acknowledge handshake and shifts it out LSB first, framed with start, optional parity and stop bits. Runs on the 16x-baud oversampling clock shared with the link's receive side. A one-byte holding register allows a second byte to be accepted during a frame, so consecutive frames go out with no idle gap.

## Interface

- OVERSAMPLE, 16: clock cycles per bit; legal range 2..16; sets the 4-bit tick counter.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

- CLK_RX  in  1  16x-baud oversampling clock; all state on rising edge.
- RST  in  1  reset, synchronous, active-low.
- DATA  in  8  byte to send; host holds it stable while WR=1 and WR_ACK=0.
- WR  in  1  write request, level, asynchronous to CLK_RX.
- WR_ACK  out  1  acknowledge, registered.
- TX  out  1  serial line, registered, idle high.
- BUSY  out  1  holding register full or frame in progress.

## Operation

- WR passes through two synchronizer flops (wr_s1, wr_s2). No other input is synchronized. DATA is sampled only on the accept edge.
- Accept condition: wr_s2=1, WR_ACK=0 and hold_full=0.
  - On accept: hold <= DATA, hold_full <= 1, WR_ACK <= 1.
  - WR_ACK stays 1 while wr_s2=1 and clears on the first edge with wr_s2=0.
  - One WR pulse sends exactly one byte, however long WR stays high.
- If hold_full=1 when wr_s2 rises, acceptance waits until hold_full clears. WR_ACK stays 0 until then.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX=1. If hold_full: shifter <= hold, hold_full <= 0, parity bit computed from hold, go to START.
  - START: TX=0 for OVERSAMPLE cycles.
  - DATA: shifter bit 0 on TX; shift right every OVERSAMPLE cycles; 8 bits, bit counter 0..7.
  - PARITY: entered only when PARITY != 0. TX = ^byte for even, ~^byte for odd, for OVERSAMPLE cycles.
  - STOP: TX=1 for OVERSAMPLE*STOP_BITS cycles.
- At the last cycle of STOP:
  - if hold_full=1: load the shifter and go directly to START (back-to-back, no idle cycle);
  - else go to IDLE.
- Tick counter: loaded with OVERSAMPLE-1 on every state or bit entry, counts down. Advance happens at count 0. It wraps only by reload and never underflows.
- BUSY = hold_full | (state != IDLE), registered with the same update as its sources.
- Reset values: TX=1, WR_ACK=0, BUSY=0, state IDLE, hold_full=0, wr_s1=wr_s2=0, counters 0.
- Reset mid-frame aborts the frame. TX goes to 1 at the reset edge and the held byte is discarded. If WR is still high after reset, it is re-accepted as a new request after the synchronizer delay.

## Timing

- Let WR be first sampled high at edge k.
  - Edge k+1: wr_s2=1.
  - Edge k+2: accept; WR_ACK=1, hold_full=1, BUSY=1.
  - Edge k+3: START, TX=0.
- Frame length in cycles: OVERSAMPLE*(1+8+P+STOP_BITS), where P=1 if parity is enabled, else 0. Default 8N1: 160 cycles.
- Back-to-back: the next start bit begins on the edge after the last stop cycle. Frame period is exactly the frame length.
- WR falling at edge m: WR_ACK=0 after edge m+2. A new request is then accepted no earlier than 2 edges after WR rises again.
- The earliest second accept occurs 1 edge after the shifter load, i.e. during START of the current frame.

## Test plan

- 8N1, DATA=0x55, one WR pulse:
  - TX=0 from edge k+3;
  - then 1,0,1,0,1,0,1,0 at 16 cycles each;
  - stop 1 for 16 cycles;
  - BUSY falls 160 cycles after TX fell;
  - WR_ACK rises at k+2.
- Back-to-back 0xA5 then 0x3C:
  - second WR raised mid-frame is acknowledged during frame 1;
  - frame 2's start bit immediately follows frame 1's stop bit;
  - 320 cycles of continuous framing, no idle high beyond the stop bits.
- PARITY=1 with 0x07: parity bit 1. PARITY=2 with 0x07: parity bit 0. STOP_BITS=2: stop high for exactly 32 cycles; frame length 192 cycles with parity.
- WR held high for 1000 cycles with DATA=0x81:
  - exactly one frame sent;
  - WR_ACK stays 1 until 2 edges after WR falls.
- Two bytes queued while a frame is active (hold full), then a third WR:
  - third WR_ACK is withheld until the second byte loads into the shifter;
  - no byte lost or duplicated.
- RST low mid-DATA state of 0x00: TX=1 at the reset edge, BUSY=0, WR_ACK=0. After RST high with WR low, the line stays idle with no residual frame.
